// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared memory request types, line width, arbiter states and requester ids
package mem_req_arbiter_pkg;
  localparam int DCACHE_LINE_WIDTH = 128;
  localparam logic MEM_ID_ICACHE = 1'b0;
  localparam logic MEM_ID_DCACHE = 1'b1;
  typedef struct packed {
    logic [31:0]                  addr;
    logic                         is_write;
    logic [DCACHE_LINE_WIDTH-1:0] wdata;
  } memory_request_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT_RSP} mem_arb_state_t;
endpackage

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-outstanding I$/D$ miss arbiter with D$ priority onto one memory port
// Optional I$ anti-starvation counter enabled by defining MEM_ARB_STARVE_EN.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         icache_req_valid,
  input  memory_request_t              icache_req_info,
  output logic                         icache_req_grant,
  input  logic                         dcache_req_valid,
  input  memory_request_t              dcache_req_info,
  output logic                         dcache_req_grant,
  output logic                         mem_req_valid,
  output memory_request_t              mem_req_info,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [DCACHE_LINE_WIDTH-1:0] mem_rsp_data,
  output logic                         rsp_valid_miss,
  output logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss,
  output logic                         rsp_cache_id
);
  mem_arb_state_t state_q, state_d;
  memory_request_t info_q;
  logic owner_q, idle, pick_d, take;
  // Grants are forced low while reset is asserted so all outputs read 0 during reset.
  assign idle             = reset & (state_q == ARB_IDLE);
  assign dcache_req_grant = idle & pick_d;
  assign icache_req_grant = idle & icache_req_valid & ~pick_d;
  assign take             = dcache_req_grant | icache_req_grant;
  assign mem_req_valid    = state_q == ARB_REQ;
  assign mem_req_info     = info_q;

`ifdef MEM_ARB_STARVE_EN
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic starved;
  assign starved = starve_cnt_q == CNT_W'(STARVE_LIMIT);
  assign pick_d  = dcache_req_valid & ~(starved & icache_req_valid);
  always_comb begin
    starve_cnt_d = (!icache_req_valid || icache_req_grant) ? '0 :
                   (dcache_req_grant && !starved) ? starve_cnt_q + 1'b1 : starve_cnt_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  assign pick_d = dcache_req_valid;
`endif

  always_comb begin
    state_d = (state_q == ARB_IDLE && take)               ? ARB_REQ      :
              (state_q == ARB_REQ && mem_req_ready)       ? ARB_WAIT_RSP :
              (state_q == ARB_WAIT_RSP && mem_rsp_valid)  ? ARB_IDLE     : state_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ARB_IDLE;
      info_q         <= '0;
      owner_q        <= MEM_ID_ICACHE;
      rsp_valid_miss <= 1'b0;
      rsp_data_miss  <= '0;
      rsp_cache_id   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rsp_valid_miss <= 1'b0;
      if (take) begin
        info_q  <= pick_d ? dcache_req_info : icache_req_info;
        owner_q <= pick_d ? MEM_ID_DCACHE : MEM_ID_ICACHE;
      end
      if (state_q == ARB_WAIT_RSP && mem_rsp_valid) begin
        rsp_valid_miss <= 1'b1;
        rsp_data_miss  <= mem_rsp_data;
        rsp_cache_id   <= owner_q;
      end
    end
  end
endmodule
